// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity, one stop bit.
// Define UART_TX_HOLD_REG_EN to add a one-byte holding register for back-to-back frames.
module uart_tx #(
    parameter int unsigned CLOCK_DIVIDER_WIDTH = 16
) (
    input  logic                           clock_i,
    input  logic                           reset_n_i,
    input  logic                           send_i,
    input  logic [7:0]                     data_i,
    input  logic                           parity_bit_i,
    input  logic                           parity_even_i,
    input  logic [CLOCK_DIVIDER_WIDTH-1:0] clock_divider_i,
    output logic                           serial_o,
    output logic                           ready_o,
    output logic                           busy_o
);

    localparam logic [CLOCK_DIVIDER_WIDTH-1:0] One = CLOCK_DIVIDER_WIDTH'(1);
    localparam logic [CLOCK_DIVIDER_WIDTH-1:0] Two = CLOCK_DIVIDER_WIDTH'(2);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    state_e                         state_q;
    logic                           pend_q;
    logic [7:0]                     shift_q;
    logic                           par_en_q;
    logic                           par_val_q;
    logic [CLOCK_DIVIDER_WIDTH-1:0] div_q;
    logic [CLOCK_DIVIDER_WIDTH-1:0] timer_q;
    logic [2:0]                     bit_cnt_q;
    logic                           send_trig_q;
    logic                           serial_q;
    logic                           ready_q;
    logic                           busy_q;

    logic accept;
    logic bit_done;
    logic stop_end;
    logic par_in;
    logic direct;

    assign accept   = send_i && ready_q && !send_trig_q && (clock_divider_i >= Two);
    assign bit_done = (timer_q == '0);
    assign stop_end = (state_q == StStop) && bit_done;
    assign par_in   = (^data_i) ^ (~parity_even_i);

`ifdef UART_TX_HOLD_REG_EN
    logic                           hold_valid_q;
    logic [7:0]                     hold_data_q;
    logic                           hold_par_en_q;
    logic                           hold_par_val_q;
    logic [CLOCK_DIVIDER_WIDTH-1:0] hold_div_q;
    logic                           to_hold;
    logic                           drain;
    logic                           hold_valid_d;

    // A byte goes straight to the shifter only when no frame is pending, running or about to chain.
    assign direct       = ((state_q == StIdle) && !pend_q) || (stop_end && !hold_valid_q);
    assign to_hold      = accept && !direct;
    assign drain        = stop_end && hold_valid_q;
    assign hold_valid_d = to_hold || (hold_valid_q && !drain);
`else
    assign direct = 1'b1;
`endif

    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            state_q     <= StIdle;
            pend_q      <= 1'b0;
            shift_q     <= '0;
            par_en_q    <= 1'b0;
            par_val_q   <= 1'b0;
            div_q       <= '0;
            timer_q     <= '0;
            bit_cnt_q   <= '0;
            send_trig_q <= 1'b0;
            serial_q    <= 1'b1;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
`ifdef UART_TX_HOLD_REG_EN
            hold_valid_q   <= 1'b0;
            hold_data_q    <= '0;
            hold_par_en_q  <= 1'b0;
            hold_par_val_q <= 1'b0;
            hold_div_q     <= '0;
`endif
        end else begin
            if (!send_i) begin
                send_trig_q <= 1'b0;
            end else if (accept) begin
                send_trig_q <= 1'b1;
            end

            if (!bit_done) begin
                timer_q <= timer_q - One;
            end

            case (state_q)
                StIdle: begin
                    if (pend_q) begin
                        pend_q   <= 1'b0;
                        state_q  <= StStart;
                        serial_q <= 1'b0;
                        busy_q   <= 1'b1;
                        timer_q  <= div_q - One;
                    end
                end
                StStart: begin
                    if (bit_done) begin
                        state_q   <= StData;
                        serial_q  <= shift_q[0];
                        bit_cnt_q <= '0;
                        timer_q   <= div_q - One;
                    end
                end
                StData: begin
                    if (bit_done) begin
                        timer_q <= div_q - One;
                        if (bit_cnt_q == 3'd7) begin
                            if (par_en_q) begin
                                state_q  <= StParity;
                                serial_q <= par_val_q;
                            end else begin
                                state_q  <= StStop;
                                serial_q <= 1'b1;
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            shift_q   <= {1'b0, shift_q[7:1]};
                            serial_q  <= shift_q[1];
                        end
                    end
                end
                StParity: begin
                    if (bit_done) begin
                        state_q  <= StStop;
                        serial_q <= 1'b1;
                        timer_q  <= div_q - One;
                    end
                end
                StStop: begin
                    if (bit_done) begin
`ifdef UART_TX_HOLD_REG_EN
                        if (hold_valid_q) begin
                            // Chain the held byte: start bit follows the stop bit with no gap.
                            state_q   <= StStart;
                            serial_q  <= 1'b0;
                            shift_q   <= hold_data_q;
                            par_en_q  <= hold_par_en_q;
                            par_val_q <= hold_par_val_q;
                            div_q     <= hold_div_q;
                            timer_q   <= hold_div_q - One;
                        end else begin
                            state_q  <= StIdle;
                            serial_q <= 1'b1;
                            busy_q   <= 1'b0;
                        end
`else
                        state_q  <= StIdle;
                        serial_q <= 1'b1;
                        busy_q   <= 1'b0;
`endif
                    end
                end
                default: state_q <= StIdle;
            endcase

            if (accept && direct) begin
                shift_q   <= data_i;
                par_en_q  <= parity_bit_i;
                par_val_q <= par_in;
                div_q     <= clock_divider_i;
                pend_q    <= 1'b1;
            end

`ifdef UART_TX_HOLD_REG_EN
            hold_valid_q <= hold_valid_d;
            ready_q      <= !hold_valid_d;
            if (to_hold) begin
                hold_data_q    <= data_i;
                hold_par_en_q  <= parity_bit_i;
                hold_par_val_q <= par_in;
                hold_div_q     <= clock_divider_i;
            end
`else
            if (accept) begin
                ready_q <= 1'b0;
            end else if (stop_end) begin
                ready_q <= 1'b1;
            end
`endif
        end
    end

    assign serial_o = serial_q;
    assign ready_o  = ready_q;
    assign busy_o   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: directed and random frames against a frame-level model.
module tb_uart_tx;

    localparam int W = 16;
`ifdef UART_TX_HOLD_REG_EN
    localparam logic HOLD = 1'b1;
`else
    localparam logic HOLD = 1'b0;
`endif

    logic         clock_i = 1'b0;
    logic         reset_n_i;
    logic         send_i;
    logic [7:0]   data_i;
    logic         parity_bit_i;
    logic         parity_even_i;
    logic [W-1:0] clock_divider_i;
    logic         serial_o;
    logic         ready_o;
    logic         busy_o;

    int errors = 0;
    int checks = 0;

    always #5 clock_i = ~clock_i;

    uart_tx #(.CLOCK_DIVIDER_WIDTH(W)) dut (
        .clock_i         (clock_i),
        .reset_n_i       (reset_n_i),
        .send_i          (send_i),
        .data_i          (data_i),
        .parity_bit_i    (parity_bit_i),
        .parity_even_i   (parity_even_i),
        .clock_divider_i (clock_divider_i),
        .serial_o        (serial_o),
        .ready_o         (ready_o),
        .busy_o          (busy_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Line levels of one frame, index = bit slot (start, d0..d7, [parity], stop).
    function automatic logic [10:0] frame_bits(input logic [7:0] d, input logic pb, input logic pe);
        logic [10:0] f;
        int ones;
        f = '1;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[1 + i] = d[i];
        ones = $countones(d);
        if (pb) f[9] = pe ? logic'(ones % 2) : logic'((ones % 2) == 0);
        return f;
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "/serial"}, serial_o, 1);
        check({tag, "/ready"}, ready_o, 1);
        check({tag, "/busy"}, busy_o, 0);
    endtask

    // Request one frame and follow it bit period by bit period; drop=1 releases send_i and
    // scrambles the inputs so the captured copy must be used.
    task automatic run_frame(input logic [7:0] d, input logic pb, input logic pe, input int div,
                             input logic drop, input string tag);
        logic [10:0] f;
        int n;
        f = frame_bits(d, pb, pe);
        n = 10 + int'(pb);
        @(negedge clock_i);
        data_i = d; parity_bit_i = pb; parity_even_i = pe;
        clock_divider_i = W'(div); send_i = 1'b1;
        @(posedge clock_i); #1;
        check({tag, "/accept_ready"}, ready_o, HOLD);
        check({tag, "/accept_busy"}, busy_o, 0);
        for (int k = 0; k < n * div; k++) begin
            @(negedge clock_i);
            if (drop) begin
                send_i = 1'b0;
                data_i = 8'($urandom);
                parity_bit_i = 1'($urandom);
                parity_even_i = 1'($urandom);
                clock_divider_i = W'($urandom_range(2, 7));
            end
            @(posedge clock_i); #1;
            check({tag, "/serial"}, serial_o, f[k / div]);
            check({tag, "/busy"}, busy_o, 1);
            check({tag, "/ready"}, ready_o, HOLD);
        end
        @(posedge clock_i); #1;
        check_idle({tag, "/end"});
    endtask

    initial begin
        reset_n_i = 1'b0; send_i = 1'b0; data_i = '0;
        parity_bit_i = 1'b0; parity_even_i = 1'b0; clock_divider_i = W'(4);
        repeat (3) @(posedge clock_i);
        #1;
        check_idle("reset");
        @(negedge clock_i); reset_n_i = 1'b1;

        run_frame(8'hA5, 1'b0, 1'b0, 4, 1'b1, "t1_a5");
        run_frame(8'h03, 1'b1, 1'b1, 3, 1'b1, "t2_even");
        run_frame(8'h03, 1'b1, 1'b0, 3, 1'b1, "t2_odd");

        // Held send_i: one frame only, then nothing until it drops and rises again.
        run_frame(8'h0F, 1'b0, 1'b0, 2, 1'b0, "t3_held");
        repeat (78) begin
            @(posedge clock_i); #1;
            check("t3_hold_busy", busy_o, 0);
            check("t3_hold_serial", serial_o, 1);
        end
        @(negedge clock_i); send_i = 1'b0;
        run_frame(8'h0F, 1'b0, 1'b0, 2, 1'b1, "t3_again");

        // Invalid divider is ignored and must not arm the trigger flag.
        @(negedge clock_i); send_i = 1'b1; clock_divider_i = W'(1); data_i = 8'hFF;
        repeat (4) begin
            @(posedge clock_i); #1;
            check_idle("t4_div1");
        end
        run_frame(8'h3C, 1'b0, 1'b0, 4, 1'b1, "t4_valid_after");

        // Reset in the middle of a frame.
        @(negedge clock_i);
        data_i = 8'h00; parity_bit_i = 1'b0; clock_divider_i = W'(4); send_i = 1'b1;
        @(posedge clock_i);
        @(negedge clock_i); send_i = 1'b0;
        repeat (13) @(posedge clock_i);
        #1;
        check("t5_inflight_busy", busy_o, 1);
        @(negedge clock_i); reset_n_i = 1'b0;
        @(posedge clock_i); #1;
        check_idle("t5_reset");
        @(negedge clock_i); reset_n_i = 1'b1;
        run_frame(8'h96, 1'b1, 1'b1, 4, 1'b1, "t5_after");

        for (int r = 0; r < 6; r++) begin
            run_frame(8'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(2, 5)),
                      1'b1, "rand");
        end

`ifdef UART_TX_HOLD_REG_EN
        begin
            logic [10:0] f1;
            logic [10:0] f2;
            logic        exp_bit;
            f1 = frame_bits(8'h55, 1'b0, 1'b0);
            f2 = frame_bits(8'hAA, 1'b0, 1'b0);
            @(negedge clock_i);
            data_i = 8'h55; parity_bit_i = 1'b0; clock_divider_i = W'(2); send_i = 1'b1;
            @(posedge clock_i); #1;
            check("t6_accept_ready", ready_o, 1);
            for (int k = 1; k <= 40; k++) begin
                @(negedge clock_i);
                send_i = (k == 5);
                if (k == 5) data_i = 8'hAA;
                @(posedge clock_i); #1;
                exp_bit = (k <= 20) ? f1[(k - 1) / 2] : f2[(k - 21) / 2];
                check("t6_serial", serial_o, exp_bit);
                check("t6_busy", busy_o, 1);
                check("t6_ready", ready_o, !(k >= 5 && k <= 20));
            end
            @(negedge clock_i); send_i = 1'b0;
            @(posedge clock_i); #1;
            check_idle("t6_end");
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
